shot_dispatcher: RTL
====================

// Module: shot_dispatcher
// PURPOSE
// - Turns the player fire request into one-cycle deploy pulses for the shot pool (deploy_shot[i] -> shotLogic[i]).
// - Picks the lowest-index idle shot slot and paces fire with a frame-based cooldown.
// - Sits between the fire input (KEY[2]/SW[0] autofire) and the generated shot instances; replaces ad-hoc deploy logic in game_controller.
// PARAMETERS
// - NUM_SHOTS       8   shot slots in the pool; width of shots_active/deploy_shot
// - COOLDOWN_FRAMES 6   frames between accepted shots (0 = next frame)
// - MAX_AMMO        8   ammo capacity (AMMO_EN only)
// - RELOAD_FRAMES   30  frames per +1 ammo refill (AMMO_EN only); must be >=1
// PORTS
// - clk           in   1          system clock, 50 MHz; the only clock
// - reset         in   1          asynchronous, active-high reset
// - startOfFrame  in   1          one-cycle pulse per VGA frame
// - shoot         in   1          fire request, level; held high = autofire
// - shots_active  in   NUM_SHOTS  slot i currently in flight
// - deploy_shot   out  NUM_SHOTS  one-hot, one-cycle deploy strobe
// - shot_fired    out  1          one-cycle pulse, coincident with deploy_shot
// - cooling       out  1          high while in COOLDOWN
// - ammo          out  $clog2(MAX_AMMO+1)  remaining ammo
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; deploy_shot=0, shot_fired=0, cooling=0; cooldown counter=0.
//   ammo=MAX_AMMO; reload counter=0.
// - All outputs are registered.
// - FSM: IDLE, DEPLOY, COOLDOWN.
// - IDLE: a request is accepted only in a cycle with startOfFrame=1 and shoot=1,
//   with at least one shots_active bit 0 (and ammo>0 under AMMO_EN).
//   - On accept: latch slot = lowest i with shots_active[i]==0, sampled that same cycle; go to DEPLOY.
//   - Otherwise stay in IDLE. The request is not queued; it is re-evaluated on the next frame.
// - DEPLOY (exactly 1 cycle): deploy_shot=1<<slot, shot_fired=1.
//   - Load the cooldown counter with COOLDOWN_FRAMES and go to COOLDOWN, or go to IDLE when COOLDOWN_FRAMES==0.
//   - Latency: the deploy pulse appears the cycle after the accepting startOfFrame.
// - COOLDOWN: cooling=1. The counter decrements on each startOfFrame.
//   - In the startOfFrame cycle where the counter is 1, go to IDLE.
//   - The first new accept is COOLDOWN_FRAMES+1 frames after the previous one (autofire period).
// - shots_active changes during DEPLOY or COOLDOWN are ignored. The latched slot is deployed even if it went active meanwhile.
// - shoot falling during COOLDOWN does not shorten the cooldown.
// - All slots busy in IDLE: no pulse, no state change, no ammo consumed.
// - Counters saturate and never wrap. The cooldown counter is $clog2(COOLDOWN_FRAMES+1) bits, with a minimum of 1.
// CONFIGURATION
// - Macro SHOT_DISPATCHER_AMMO_EN defined:
//   - ammo decrements by 1 in the DEPLOY cycle.
//   - The reload counter counts startOfFrame pulses. On reaching RELOAD_FRAMES it clears and adds 1 to ammo, saturating at MAX_AMMO.
//   - The reload counter is held at 0 while ammo==MAX_AMMO.
//   - Accept requires ammo>0, evaluated on the pre-reload value of that cycle.
//   - Reload and decrement never share a cycle, because DEPLOY is never a startOfFrame cycle.
// - Macro undefined: no ammo logic is synthesised. ammo is tied to MAX_AMMO and firing is limited only by cooldown and free slots.
// TESTING
// 1. reset=1 mid-DEPLOY -> same cycle deploy_shot=0, shot_fired=0, cooling=0, ammo=MAX_AMMO; after release the FSM is in IDLE.
// 2. shots_active=8'b0000_0111, shoot=1, one startOfFrame
//    -> next cycle deploy_shot=8'b0000_1000 for exactly 1 cycle; cooling=1 from the following cycle.
// 3. shoot held high, all slots free, COOLDOWN_FRAMES=6
//    -> shot_fired at frames 0, 7, 14 and slots 0, 1, 2 deployed in order (shots_active tracked by the bench).
// 4. shots_active=8'hFF, shoot=1 for 3 frames -> no deploy pulse.
//    Clear bit 5 in the third frame -> deploy_shot=8'h20 after that frame's startOfFrame.
// 5. AMMO_EN, MAX_AMMO=2, RELOAD_FRAMES=30, COOLDOWN_FRAMES=0, autofire
//    -> 2 shots on consecutive frames; ammo=0 with no shot;
//    after 30 frames (counted from the first shot) ammo=1 and 1 shot follows on the next frame.
// 6. AMMO_EN undefined, same stimulus as 5 -> shots continue every frame; ammo reads constant 2.

Source files
------------

// File: rtl/shot_dispatcher.sv
// shot_dispatcher: turns the player fire request into one-cycle deploy
// strobes for the shot pool. It picks the lowest-index idle slot and
// paces autofire with a frame-based cooldown.
// Optional ammo/reload logic is enabled with `define SHOT_DISPATCHER_AMMO_EN.
// Without it, ammo reads a constant MAX_AMMO and never limits fire.
module shot_dispatcher #(
  parameter int NUM_SHOTS       = 8,
  parameter int COOLDOWN_FRAMES = 6,
  parameter int MAX_AMMO        = 8,
  parameter int RELOAD_FRAMES   = 30
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             startOfFrame,
  input  logic                             shoot,
  input  logic [NUM_SHOTS-1:0]             shots_active,
  output logic [NUM_SHOTS-1:0]             deploy_shot,
  output logic                             shot_fired,
  output logic                             cooling,
  output logic [$clog2(MAX_AMMO+1)-1:0]    ammo
);

  localparam int SLOT_W = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1;
  localparam int CD_W_RAW = $clog2(COOLDOWN_FRAMES + 1);
  localparam int CD_W = (CD_W_RAW < 1) ? 1 : CD_W_RAW;
  localparam int AMMO_W = $clog2(MAX_AMMO + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);
  localparam logic [AMMO_W-1:0] AMMO_MAX = AMMO_W'(MAX_AMMO);

  typedef enum logic [1:0] {
    IDLE,
    DEPLOY,
    COOLDOWN
  } state_t;

  state_t state;
  state_t next_state;

  logic [CD_W-1:0]   cd_cnt;
  logic [SLOT_W-1:0] free_slot;
  logic              any_free;
  logic              ammo_ok;
  logic              accept;

  // Lowest-index idle slot, scanned from the top so the lowest hit wins
  always_comb begin
    free_slot = '0;
    for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
      if (!shots_active[i]) begin
        free_slot = SLOT_W'(i);
      end
    end
  end

  assign any_free = ~&shots_active;
  assign accept   = startOfFrame & shoot & any_free & ammo_ok;

`ifdef SHOT_DISPATCHER_AMMO_EN
  localparam int RL_W_RAW = $clog2(RELOAD_FRAMES + 1);
  localparam int RL_W = (RL_W_RAW < 1) ? 1 : RL_W_RAW;
  localparam logic [RL_W-1:0] RL_LAST = RL_W'(RELOAD_FRAMES - 1);

  logic [AMMO_W-1:0] ammo_q;
  logic [RL_W-1:0]   reload_cnt;

  // Ammo spends one round on the deploy cycle and refills one per reload period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ammo_q     <= AMMO_MAX;
      reload_cnt <= '0;
    end else if (state == DEPLOY) begin
      if (ammo_q != '0) begin
        ammo_q <= ammo_q - 1'b1;
      end
    end else if (startOfFrame) begin
      if (ammo_q >= AMMO_MAX) begin
        reload_cnt <= '0;
      end else if (reload_cnt >= RL_LAST) begin
        reload_cnt <= '0;
        ammo_q     <= ammo_q + 1'b1;
      end else begin
        reload_cnt <= reload_cnt + 1'b1;
      end
    end
  end

  assign ammo    = ammo_q;
  assign ammo_ok = (ammo_q != '0);
`else
  assign ammo    = AMMO_MAX;
  assign ammo_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decision: accept on a frame, deploy for one cycle, then cool down
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = DEPLOY;
        end
      end
      DEPLOY: begin
        next_state = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
      end
      COOLDOWN: begin
        if (startOfFrame && (cd_cnt <= CD_W'(1))) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Cooldown counter loads on deploy and counts frames down, never wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cd_cnt <= '0;
    end else if (state == DEPLOY) begin
      cd_cnt <= CD_LOAD;
    end else if ((state == COOLDOWN) && startOfFrame && (cd_cnt != '0)) begin
      cd_cnt <= cd_cnt - 1'b1;
    end
  end

  // Registered outputs; the slot is captured on the accepting cycle and held through deploy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deploy_shot <= '0;
      shot_fired  <= 1'b0;
      cooling     <= 1'b0;
    end else begin
      deploy_shot <= (next_state == DEPLOY) ? (NUM_SHOTS'(1) << free_slot) : '0;
      shot_fired  <= (next_state == DEPLOY);
      cooling     <= (next_state == COOLDOWN);
    end
  end

endmodule
